aib_rx_word_align: RTL and testbench

AIB_RX_WORD_ALIGN -- requirements
Module: aib_rx_word_align

---
 rtl/aib_rx_word_align_pkg.sv | 26 ++
 rtl/aib_rx_word_align_if.sv | 31 +++
 rtl/aib_rx_word_align_match.sv | 32 +++
 rtl/aib_rx_word_align.sv | 122 ++++++++++++
 tb/tb_aib_rx_word_align.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/aib_rx_word_align_pkg.sv
// aib_pkg: word width, default training word and aligner FSM states.
// Shared by the match sub-module, the aligner top and its interface.
package aib_pkg;

  localparam int AIB_WORD_W = 40;
  localparam int AIB_HALF_W = AIB_WORD_W / 2;
  localparam int AIB_OFF_W  = 6;

  localparam logic [AIB_WORD_W-1:0] AIB_TRAIN_PATTERN =
    40'h5A_F0C3_3CA5;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  // 40-bit slice of the 80-bit window starting at bit off.
  function automatic logic [AIB_WORD_W-1:0] win_slice(
    input logic [2*AIB_WORD_W-1:0] win,
    input logic [AIB_OFF_W-1:0]    off
  );
    return AIB_WORD_W'(win >> off);
  endfunction

endpackage

// File: rtl/aib_rx_word_align_if.sv
// aib_rx_word_align_if: raw RX halves in, aligned word and status out.
// slave = aligner side, master = PHY/consumer side.
interface aib_rx_word_align_if;
  import aib_pkg::*;

  logic [AIB_HALF_W-1:0] i_aib_rx_data0;
  logic [AIB_HALF_W-1:0] i_aib_rx_data1;
  logic                  o_rx_valid;
  logic [AIB_WORD_W-1:0] o_rx_data;
  logic                  o_locked;
  logic [AIB_OFF_W-1:0]  o_align_offset;

  modport master (
    output i_aib_rx_data0,
    output i_aib_rx_data1,
    input  o_rx_valid,
    input  o_rx_data,
    input  o_locked,
    input  o_align_offset
  );

  modport slave (
    input  i_aib_rx_data0,
    input  i_aib_rx_data1,
    output o_rx_valid,
    output o_rx_data,
    output o_locked,
    output o_align_offset
  );

endinterface

// File: rtl/aib_rx_word_align_match.sv
// aib_align_match: compares all 40 window slices with the pattern.
// Ports: i_win/i_pattern in; o_hit, o_first_off (lowest), o_hit_vec out.
module aib_align_match
  import aib_pkg::*;
(
  input  logic [2*AIB_WORD_W-1:0] i_win,
  input  logic [AIB_WORD_W-1:0]   i_pattern,
  output logic                    o_hit,
  output logic [AIB_OFF_W-1:0]    o_first_off,
  output logic [AIB_WORD_W-1:0]   o_hit_vec
);

  always_comb begin
    o_hit_vec = '0;
    for (int k = 0; k < AIB_WORD_W; k++) begin
      o_hit_vec[k] = (i_win[k +: AIB_WORD_W] == i_pattern);
    end
  end

  // Scan downward so the lowest matching offset is the last write.
  always_comb begin
    o_first_off = '0;
    for (int k = AIB_WORD_W - 1; k >= 0; k--) begin
      if (o_hit_vec[k]) begin
        o_first_off = AIB_OFF_W'(k);
      end
    end
  end

  assign o_hit = |o_hit_vec;

endmodule

// File: rtl/aib_rx_word_align.sv
// aib_rx_word_align: finds the 40-bit word boundary in the AIB RX stream.
// Ports: clk, sync rst_n, bypass cfg, realign pulse, rx (slave) bus.
module aib_rx_word_align
  import aib_pkg::*;
#(
  parameter logic [AIB_WORD_W-1:0] TRAIN_PATTERN = AIB_TRAIN_PATTERN,
  parameter int                    LOCK_CNT      = 4
) (
  input  logic                i_aib_rx_clk,
  input  logic                i_rst_n,
  input  logic                c_bypass_word_align,
  input  logic                i_realign,
  aib_rx_word_align_if.slave  rx
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  logic [AIB_WORD_W-1:0]   cur;
  logic [AIB_WORD_W-1:0]   prev_q;
  logic [2*AIB_WORD_W-1:0] win;

  logic                    hit;
  logic [AIB_OFF_W-1:0]    first_off;
  logic [AIB_WORD_W-1:0]   hit_vec;

  align_state_t            state_q;
  logic [3:0]              match_cnt_q;
  logic [3:0]              cnt_inc;
  logic [AIB_OFF_W-1:0]    offset_q;
  logic                    verify_ok;

  logic [AIB_WORD_W-1:0]   rx_data_q;
  logic                    rx_valid_q;
  logic                    locked_q;

  assign cur = {rx.i_aib_rx_data1, rx.i_aib_rx_data0};
  assign win = {cur, prev_q};

  aib_align_match u_match (
    .i_win       (win),
    .i_pattern   (TRAIN_PATTERN),
    .o_hit       (hit),
    .o_first_off (first_off),
    .o_hit_vec   (hit_vec)
  );

  // A lower-offset hit takes priority, so it counts as a miss here.
  assign verify_ok = hit_vec[offset_q] && (first_off == offset_q);
  assign cnt_inc   = match_cnt_q + 4'd1;

  always_ff @(posedge i_aib_rx_clk) begin
    if (!i_rst_n) begin
      prev_q      <= '0;
      state_q     <= HUNT;
      match_cnt_q <= '0;
      offset_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      prev_q <= cur;
      if (c_bypass_word_align) begin
        state_q     <= HUNT;
        match_cnt_q <= '0;
        locked_q    <= 1'b0;
        rx_data_q   <= cur;
        rx_valid_q  <= 1'b1;
      end else if (i_realign) begin
        state_q     <= HUNT;
        match_cnt_q <= '0;
        locked_q    <= 1'b0;
        rx_valid_q  <= 1'b0;
      end else begin
        unique case (state_q)
          HUNT: begin
            rx_valid_q <= 1'b0;
            if (hit) begin
              offset_q    <= first_off;
              match_cnt_q <= 4'd1;
              if (LOCK_N == 4'd1) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                state_q <= VERIFY;
              end
            end
          end
          VERIFY: begin
            rx_valid_q <= 1'b0;
            if (verify_ok) begin
              match_cnt_q <= cnt_inc;
              if (cnt_inc == LOCK_N) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              match_cnt_q <= '0;
              state_q     <= HUNT;
            end
          end
          LOCKED: begin
            rx_data_q  <= win_slice(win, offset_q);
            rx_valid_q <= 1'b1;
            locked_q   <= 1'b1;
          end
          default: begin
            state_q     <= HUNT;
            match_cnt_q <= '0;
            locked_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx.o_rx_valid     = rx_valid_q;
  assign rx.o_rx_data      = rx_data_q;
  assign rx.o_locked       = locked_q;
  assign rx.o_align_offset = offset_q;

endmodule

// File: tb/tb_aib_rx_word_align.sv
// tb_aib_rx_word_align: random + directed checks of the word aligner.
// Reference model tracks the match streak per transmitted bit offset.
module tb_aib_rx_word_align;
  import aib_pkg::*;

  localparam logic [39:0] PAT  = 40'h5A_F0C3_3CA5;
  localparam int          LCNT = 4;
  localparam logic [39:0] PER  = 40'hABCDE_ABCDE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic bypass;
  logic realign;

  aib_rx_word_align_if rx ();

  aib_rx_word_align #(
    .TRAIN_PATTERN (PAT),
    .LOCK_CNT      (LCNT)
  ) dut (
    .i_aib_rx_clk        (clk),
    .i_rst_n             (rst_n),
    .c_bypass_word_align (bypass),
    .i_realign           (realign),
    .rx                  (rx)
  );

  logic [79:0] pw;
  logic        p_hit;
  logic [5:0]  p_off;
  logic [39:0] p_vec;

  aib_align_match u_prio (
    .i_win       (pw),
    .i_pattern   (PER),
    .o_hit       (p_hit),
    .o_first_off (p_off),
    .o_hit_vec   (p_vec)
  );

  int n_chk;
  int n_err;

  logic [39:0] m_prev;
  logic [39:0] m_data;
  int          m_streak;
  int          m_off;
  bit          m_locked;
  bit          m_valid;

  logic [39:0] tx_prev;
  logic [39:0] tx_old;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] rnd40();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[39:0];
  endfunction

  function automatic int first_hit(input logic [79:0] w);
    for (int k = 0; k < 40; k++) begin
      if (40'(w >> k) == PAT) return k;
    end
    return -1;
  endfunction

  // Streak = consecutive words matching at the offset chosen first.
  task automatic model(input logic [39:0] cur, input bit r,
                       input bit b, input bit re);
    logic [79:0] w;
    int f;
    w = {cur, m_prev};
    if (!r) begin
      m_prev = '0; m_data = '0; m_streak = 0;
      m_off = 0; m_locked = 0; m_valid = 0;
      return;
    end
    m_prev = cur;
    if (b) begin
      m_streak = 0; m_locked = 0; m_valid = 1; m_data = cur;
    end else if (re) begin
      m_streak = 0; m_locked = 0; m_valid = 0;
    end else if (m_locked) begin
      m_valid = 1;
      m_data  = 40'(w >> m_off);
    end else begin
      m_valid = 0;
      f = first_hit(w);
      if (m_streak == 0) begin
        if (f >= 0) begin
          m_off = f;
          m_streak = 1;
        end
      end else if (f == m_off) begin
        m_streak++;
      end else begin
        m_streak = 0;
      end
      if (m_streak == LCNT) m_locked = 1;
    end
  endtask

  task automatic step(input logic [39:0] cur, input bit r,
                      input bit b, input bit re);
    rst_n   = r;
    bypass  = b;
    realign = re;
    rx.i_aib_rx_data0 = cur[19:0];
    rx.i_aib_rx_data1 = cur[39:20];
    model(cur, r, b, re);
    @(posedge clk);
    #1;
    chk("valid",  64'(rx.o_rx_valid),     64'(m_valid));
    chk("data",   64'(rx.o_rx_data),      64'(m_data));
    chk("locked", 64'(rx.o_locked),       64'(m_locked));
    chk("offset", 64'(rx.o_align_offset), 64'(m_off));
    realign = 1'b0;
  endtask

  // Transmit word tx delayed by sk bits; it lands at window offset sk.
  task automatic send(input logic [39:0] tx, input int sk,
                      input bit r, input bit b, input bit re);
    logic [39:0] cur;
    cur = 40'({tx, tx_prev} >> (40 - sk));
    tx_old  = tx_prev;
    tx_prev = tx;
    step(cur, r, b, re);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    tx_prev = '0; tx_old = '0;
    m_prev = '0; m_data = '0; m_streak = 0;
    m_off = 0; m_locked = 0; m_valid = 0;
    rst_n = 1'b0; bypass = 1'b1; realign = 1'b0;
    rx.i_aib_rx_data0 = '0;
    rx.i_aib_rx_data1 = '0;

    repeat (3) step(rnd40(), 1'b0, 1'b1, 1'b0);
    chk("rst_valid", 64'(rx.o_rx_valid), 64'd0);
    chk("rst_data",  64'(rx.o_rx_data),  64'd0);

    step(40'h12_3456_789A, 1'b1, 1'b1, 1'b0);
    chk("byp_data",  64'(rx.o_rx_data),  64'h12_3456_789A);
    chk("byp_valid", 64'(rx.o_rx_valid), 64'd1);
    chk("byp_lock",  64'(rx.o_locked),   64'd0);
    repeat (8) step(rnd40(), 1'b1, 1'b1, 1'b0);

    repeat (4) send(rnd40(), 13, 1'b1, 1'b0, 1'b0);
    send(PAT, 13, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= LCNT; i++) begin
      send(PAT, 13, 1'b1, 1'b0, 1'b0);
      chk("lock13", 64'(rx.o_locked), 64'(i == LCNT));
    end
    chk("off13", 64'(rx.o_align_offset), 64'd13);
    for (int i = 0; i < 6; i++) begin
      send(rnd40(), 13, 1'b1, 1'b0, 1'b0);
      chk("deskew", 64'(rx.o_rx_data), 64'(tx_old));
      chk("dsk_vld", 64'(rx.o_rx_valid), 64'd1);
    end

    send(PAT, 7, 1'b1, 1'b0, 1'b0);
    send(PAT, 7, 1'b1, 1'b0, 1'b1);
    chk("rea_st",  64'(dut.state_q),   64'(HUNT));
    chk("rea_vld", 64'(rx.o_rx_valid), 64'd0);
    repeat (LCNT) send(PAT, 7, 1'b1, 1'b0, 1'b0);
    chk("off7",  64'(rx.o_align_offset), 64'd7);
    chk("lock7", 64'(rx.o_locked),       64'd1);

    send(rnd40(), 13, 1'b1, 1'b0, 1'b1);
    repeat (3) begin
      send(PAT, 13, 1'b1, 1'b0, 1'b0);
      chk("mis_lock", 64'(rx.o_locked), 64'd0);
    end
    repeat (2) begin
      send(rnd40(), 13, 1'b1, 1'b0, 1'b0);
      chk("mis_lock", 64'(rx.o_locked), 64'd0);
    end
    chk("mis_cnt", 64'(dut.match_cnt_q), 64'd0);
    chk("mis_st",  64'(dut.state_q),     64'(HUNT));

    repeat (LCNT + 1) send(PAT, 13, 1'b1, 1'b0, 1'b0);
    chk("pre_rst", 64'(rx.o_locked), 64'd1);
    send(PAT, 13, 1'b0, 1'b0, 1'b0);
    chk("mrst_vld", 64'(rx.o_rx_valid),     64'd0);
    chk("mrst_dat", 64'(rx.o_rx_data),      64'd0);
    chk("mrst_lck", 64'(rx.o_locked),       64'd0);
    chk("mrst_off", 64'(rx.o_align_offset), 64'd0);
    send(PAT, 13, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= LCNT; i++) begin
      send(PAT, 13, 1'b1, 1'b0, 1'b0);
      chk("relock", 64'(rx.o_locked), 64'(i == LCNT));
    end

    send(rnd40(), 0, 1'b1, 1'b0, 1'b1);
    repeat (LCNT + 1) send(PAT, 0, 1'b1, 1'b0, 1'b0);
    chk("off0",  64'(rx.o_align_offset), 64'd0);
    chk("lock0", 64'(rx.o_locked),       64'd1);

    pw = {15'h0, 60'hABCDE_ABCDE_ABCDE, 5'h0};
    #1;
    chk("prio_off", 64'(p_off),    64'd5);
    chk("prio_v5",  64'(p_vec[5]), 64'd1);
    chk("prio_v25", 64'(p_vec[25]), 64'd1);
    chk("prio_hit", 64'(p_hit),    64'd1);

    begin
      int sk;
      bit byp;
      sk  = 0;
      byp = 1'b0;
      for (int it = 0; it < 400; it++) begin
        if ($urandom_range(0, 24) == 0) sk = $urandom_range(0, 39);
        if ($urandom_range(0, 39) == 0) byp = ~byp;
        send(($urandom_range(0, 3) != 0) ? PAT : rnd40(), sk,
             ($urandom_range(0, 79) != 0), byp,
             ($urandom_range(0, 29) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
